multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multi-cycle control FSM for the RV32I core. It replaces single-cycle decode with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles, against one shared instruction/data memory. Memory accesses use a req/ready handshake, so variable-latency memory is supported. It evaluates all six branch conditions, adds U-type instructions, traps on illegal opcodes and counts retired instructions.

Parameters:
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready is ignored and treated as 1.
INSTRET_W, 32, width of the retired-instruction counter.
ENABLE_U, 1, 1: LUI/AUIPC are decoded; 0: they are illegal.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
op  in  7  instr[6:0], taken from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU result == 0
alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome)
mem_ready  in  1  memory accepted write / read data valid
mem_req  out  1  memory access request
MemWrite  out  1  store strobe
AdrSrc  out  1  0: address = PC; 1: address = Result
IRWrite  out  1  latch instruction and OldPC
PCWrite  out  1  PC <= Result
RegWrite  out  1  register file write
Jalr  out  1  datapath clears Result[0] for the PC target
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA
illegal  out  1  sticky illegal-instruction flag
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (asynchronous): state=FETCH, instret=0, illegal=0. While reset is high, mem_req, MemWrite, IRWrite, PCWrite and RegWrite are forced to 0.
- Outputs are combinational from state, op and funct3. Unlisted strobes are 0; unlisted selects are don't-care.
- Handshake: mem_req is high in FETCH, MEMREAD and MEMWRITE. The state holds while mem_req=1 and mem_ready=0. Strobes marked "on ready" are high only in the cycle mem_ready=1.
- FETCH: AdrSrc=0; ALUSrcA=00, ALUSrcB=10, ADD; ResultSrc=10. On ready: IRWrite=1, PCWrite=1, go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD (ALUOut <= branch/jal target). ImmSrc follows op. Next state by op:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - 0110111 -> LUI, if ENABLE_U
  - 0010111 -> AUIPC, if ENABLE_U
  - anything else -> TRAP
- MEMADR: RD1 + ImmExt, ADD. Loads -> MEMREAD; stores -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. On ready -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Retires; -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 on ready. On ready: retires; -> FETCH.
- EXECR: RD1 op RD2 -> ALUWB. ALU operation by funct3:
  - 000: SUB if funct7b5, else ADD
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7b5, else SRL
  - 110: OR
  - 111: AND
- EXECI: RD1 op ImmExt -> ALUWB. Same ALU mapping as EXECR, except funct3=000 is always ADD; funct7b5 applies only to 101.
- ALUWB: ResultSrc=00, RegWrite=1. Retires; -> FETCH.
- BRANCH: RD1 vs RD2, ResultSrc=00; -> FETCH, retires.
  - beq/bne: SUB; taken = Zero / !Zero.
  - blt/bge: SLT; taken = alu_lsb / !alu_lsb.
  - bltu/bgeu: SLTU; taken = alu_lsb / !alu_lsb.
  - PCWrite = taken.
  - funct3 010 or 011 -> TRAP instead.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD; ResultSrc=00, PCWrite=1 -> ALUWB (writes OldPC+4).
- JALR1: RD1 + ImmExt -> JALR2.
- JALR2: ResultSrc=00, Jalr=1, PCWrite=1; ALUSrcA=01, ALUSrcB=10, ADD -> ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=100 -> ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=100 -> ALUWB.
- TRAP: illegal=1. All strobes are 0. The FSM stays in TRAP until reset.
- instret increments by 1 per retire, wrapping modulo 2^INSTRET_W. Retire points: MEMWB, MEMWRITE on ready, ALUWB, BRANCH.
- Reset asserted mid-access: state returns to FETCH at once and mem_req drops in the same cycle.

Test Plan:
- Reset, then mem_ready held 0 for 3 cycles then 1 -> mem_req high 4 cycles; IRWrite and PCWrite pulse once, in the ready cycle; next state DECODE.
- add x3,x1,x2 (0x002081B3), zero-wait -> FETCH, DECODE, EXECR (ALUControl=0000), ALUWB (RegWrite=1); instret 0 -> 1.
- sub, blt taken (alu_lsb=1) and bge not taken (alu_lsb=1) -> ALUControl=0001, then 0101 with PCWrite=1, then 0101 with PCWrite=0.
- lw with 2 wait states, then sw -> lw is 5+2 cycles with RegWrite in MEMWB; MemWrite is high only in the sw MEMWRITE ready cycle.
- jalr, then lui with ENABLE_U=1 -> JALR2 has Jalr=1, PCWrite=1; LUI has ALUSrcA=11, ImmSrc=100; both reach ALUWB.
- Opcode 0x7F, then lui with ENABLE_U=0 -> TRAP, illegal=1 with no strobes until reset. Separately, INSTRET_W=4 with 17 retirements -> instret=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore-style multi-cycle control FSM for an RV32I core that shares one
//   instruction/data memory. It sequences the fetch, decode, execute, memory
//   and writeback steps. Memory accesses use a req/ready handshake, so the
//   memory may take a variable number of cycles. The FSM traps on illegal
//   opcodes and counts retired instructions.
//
// Ports
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   op, funct3, funct7b5     instruction fields from the instruction register
//   Zero, alu_lsb            ALU status inputs, used to resolve branches
//   mem_ready                memory accepted the write, or read data is valid
//   mem_req, MemWrite        memory request and store strobe
//   AdrSrc, IRWrite, PCWrite,
//   RegWrite, Jalr           datapath strobes and address select
//   ResultSrc, ALUSrcA/B,
//   ImmSrc, ALUControl       datapath mux selects and ALU operation
//   illegal                  sticky illegal-instruction flag
//   instret                  retired-instruction counter (wraps)
module multicycle_controller #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int INSTRET_W     = 32,
  parameter int ENABLE_U      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 alu_lsb,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 Jalr,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [3:0]           ALUControl,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_t                 state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   retire;
  logic                   ready;
  logic                   br_taken;

  // With the handshake disabled every memory access completes in one cycle.
  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  // funct7b5 selects SUB only for register ops; for immediate ops bit 30 is
  // part of the immediate except for the shift-right encoding.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b5,
                                         input logic is_reg);
    case (f3)
      3'b000:  alu_dec = (is_reg && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  function automatic logic [2:0] imm_dec(input logic [6:0] o);
    case (o)
      OP_STORE:          imm_dec = 3'b001;
      OP_BRANCH:         imm_dec = 3'b010;
      OP_JAL:            imm_dec = 3'b011;
      OP_LUI, OP_AUIPC:  imm_dec = 3'b100;
      default:           imm_dec = 3'b000;
    endcase
  endfunction

  // funct3[0] inverts the sense of each branch pair (beq/bne, blt/bge, ...).
  always_comb begin
    br_taken = (funct3[2] ? alu_lsb : Zero) ^ funct3[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    Jalr       = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = imm_dec(op);
    ALUControl = ALU_ADD;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures OldPC + ImmExt, the branch/jal target.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:            state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          OP_LUI:            state_d = (ENABLE_U != 0) ? S_LUI : S_TRAP;
          OP_AUIPC:          state_d = (ENABLE_U != 0) ? S_AUIPC : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (ready) begin
          MemWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(funct3, funct7b5, 1'b1);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, funct7b5, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        if (funct3[2:1] == 2'b01) begin
          state_d = S_TRAP;
        end else begin
          ALUControl = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
          PCWrite    = br_taken;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        Jalr    = 1'b1;
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b100;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b100;
        state_d = S_ALUWB;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    // Strobes must not reach memory or the register file during reset,
    // even though the state register already reads FETCH.
    if (reset) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    instret_d = instret_q + INSTRET_W'(retire);
  end

  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, alu_lsb, mem_ready;

  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Jalr, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] instret;

  logic        b_mem_req, b_MemWrite, b_AdrSrc, b_IRWrite, b_PCWrite, b_RegWrite, b_Jalr, b_illegal;
  logic [1:0]  b_ResultSrc, b_ALUSrcA, b_ALUSrcB;
  logic [2:0]  b_ImmSrc;
  logic [3:0]  b_ALUControl;
  logic [3:0]  b_instret;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ret = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .Jalr(Jalr), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal(illegal), .instret(instret)
  );

  multicycle_controller #(.MEM_HANDSHAKE(1), .INSTRET_W(4), .ENABLE_U(0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .MemWrite(b_MemWrite), .AdrSrc(b_AdrSrc), .IRWrite(b_IRWrite),
    .PCWrite(b_PCWrite), .RegWrite(b_RegWrite), .Jalr(b_Jalr), .ResultSrc(b_ResultSrc),
    .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ImmSrc(b_ImmSrc), .ALUControl(b_ALUControl),
    .illegal(b_illegal), .instret(b_instret)
  );

  // Reference: ALU operation implied by funct3/funct7b5 for R and I forms.
  function automatic int ref_alu(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'd0: return (is_r && f7) ? 1 : 0;
      3'd1: return 7;
      3'd2: return 5;
      3'd3: return 6;
      3'd4: return 4;
      3'd5: return f7 ? 9 : 8;
      3'd6: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4, 3'd6: return l;
      default: return !l;
    endcase
  endfunction

  function automatic int ref_br_alu(input logic [2:0] f3);
    if (f3 < 3'd4) return 1;
    if (f3 < 3'd6) return 5;
    return 6;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_ret = 0;
  endtask

  // Runs one instruction with wf fetch wait states and wm data wait states,
  // acting as the memory, and checks the cycle-level behaviour against the
  // instruction-class expectations.
  task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic l,
                           input int wf, input int wm);
    int n, e_pc, e_rw, e_mw, e_req, e_jalr, e_alu;
    int c_ir, c_pc, c_rw, c_mw, c_req, c_jalr, ir_at, rw_at, mw_at, acc, wcnt, tgt;
    bit is_lui;
    n = wf + 2; e_pc = 1; e_rw = 0; e_mw = 0; e_req = wf + 1; e_jalr = 0; e_alu = -1;
    is_lui = 0;
    case (o)
      OP_R:    begin n += 2; e_rw = 1; e_alu = ref_alu(f3, f7, 1); end
      OP_I:    begin n += 2; e_rw = 1; e_alu = ref_alu(f3, f7, 0); end
      OP_LD:   begin n += 3 + wm; e_rw = 1; e_req += 1 + wm; end
      OP_ST:   begin n += 2 + wm; e_mw = 1; e_req += 1 + wm; end
      OP_BR:   begin n += 1; e_pc += int'(ref_taken(f3, z, l)); e_alu = ref_br_alu(f3); end
      OP_JAL:  begin n += 2; e_pc = 2; e_rw = 1; end
      OP_JALR: begin n += 3; e_pc = 2; e_rw = 1; e_jalr = 1; end
      default: begin n += 2; e_rw = 1; is_lui = (o == OP_LUI); end
    endcase
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; alu_lsb = l;
    c_ir = 0; c_pc = 0; c_rw = 0; c_mw = 0; c_req = 0; c_jalr = 0;
    ir_at = -1; rw_at = -1; mw_at = -1; acc = 0; wcnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (mem_req) begin
        tgt = (acc == 0) ? wf : wm;
        if (wcnt == tgt) begin mem_ready = 1'b1; wcnt = 0; acc++; end
        else begin mem_ready = 1'b0; wcnt++; end
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (mem_req)  c_req++;
      if (IRWrite)  begin c_ir++; ir_at = c; end
      if (PCWrite)  c_pc++;
      if (RegWrite) begin c_rw++; rw_at = c; end
      if (MemWrite) begin c_mw++; mw_at = c; end
      if (Jalr)     c_jalr++;
      if (c == wf + 1) begin
        n_cmp++;
        if ({mem_req, ALUSrcA, ALUSrcB} !== 5'b0_01_01) begin
          n_bad++;
          $display("FAIL %s decode_sel: got %b required 00101", nm, {mem_req, ALUSrcA, ALUSrcB});
        end
      end
      if (c == wf + 2 && e_alu >= 0) begin
        n_cmp++;
        if (ALUControl !== e_alu[3:0]) begin
          n_bad++;
          $display("FAIL %s alu_ctrl: got %b required %b", nm, ALUControl, e_alu[3:0]);
        end
      end
      if (c == wf + 2 && is_lui) begin
        n_cmp++;
        if ({ALUSrcA, ImmSrc} !== 5'b11_100) begin
          n_bad++;
          $display("FAIL %s lui_sel: got %b required 11100", nm, {ALUSrcA, ImmSrc});
        end
      end
    end
    @(posedge clk);
    #1;
    exp_ret++;
    mem_ready = 1'b0;
    n_cmp++;
    if (c_ir != 1 || ir_at != wf) begin
      n_bad++;
      $display("FAIL %s irwrite: got count %0d at %0d required 1 at %0d", nm, c_ir, ir_at, wf);
    end
    n_cmp++;
    if (c_pc != e_pc) begin
      n_bad++;
      $display("FAIL %s pcwrite_count: got %0d required %0d", nm, c_pc, e_pc);
    end
    n_cmp++;
    if (c_rw != e_rw || (e_rw == 1 && rw_at != n - 1)) begin
      n_bad++;
      $display("FAIL %s regwrite: got count %0d at %0d required %0d at %0d", nm, c_rw, rw_at, e_rw, n - 1);
    end
    n_cmp++;
    if (c_mw != e_mw || (e_mw == 1 && mw_at != n - 1)) begin
      n_bad++;
      $display("FAIL %s memwrite: got count %0d at %0d required %0d at %0d", nm, c_mw, mw_at, e_mw, n - 1);
    end
    n_cmp++;
    if (c_req != e_req) begin
      n_bad++;
      $display("FAIL %s mem_req_cycles: got %0d required %0d", nm, c_req, e_req);
    end
    n_cmp++;
    if (c_jalr != e_jalr) begin
      n_bad++;
      $display("FAIL %s jalr_count: got %0d required %0d", nm, c_jalr, e_jalr);
    end
    n_cmp++;
    if (instret !== 32'(exp_ret)) begin
      n_bad++;
      $display("FAIL %s instret: got %0d required %0d", nm, instret, exp_ret);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; alu_lsb = 1'b0; mem_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal} !== 6'b0 || instret !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: got strobes %b instret %0d required 0 and 0",
               {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal}, instret);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, AdrSrc} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_fetch: got req/adrsrc %b required 10", {mem_req, AdrSrc});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_access: got mem_req %b required 0", mem_req);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_fetch_wait();
    do_reset();
    run_instr("add_wait3", OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 3, 0);
    run_instr("add_x3", OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_alu_branch();
    run_instr("sub", OP_R, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr("blt_taken", OP_BR, 3'd4, 1'b0, 1'b0, 1'b1, 0, 0);
    run_instr("bge_not", OP_BR, 3'd5, 1'b0, 1'b0, 1'b1, 0, 0);
    run_instr("beq_taken", OP_BR, 3'd0, 1'b0, 1'b1, 1'b0, 1, 0);
    run_instr("bne_not", OP_BR, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr("addi_b5", OP_I, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr("srai", OP_I, 3'd5, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_mem();
    run_instr("lw_wait2", OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2);
    run_instr("sw", OP_ST, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("sw_wait3", OP_ST, 3'd2, 1'b0, 1'b0, 1'b0, 2, 3);
  endtask

  task automatic test_jump_u();
    run_instr("jalr", OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("jal", OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_instr("lui", OP_LUI, 3'd3, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("auipc", OP_AUIPC, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_trap();
    do_reset();
    op = 7'h7F; funct3 = 3'd0;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (IRWrite !== 1'b1) begin
      n_bad++;
      $display("FAIL trap_fetch: got IRWrite %b required 1", IRWrite);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if ({illegal, mem_req, MemWrite, IRWrite, PCWrite, RegWrite} !== 6'b100000 || instret !== 32'd0) begin
        n_bad++;
        $display("FAIL trap_hold: got %b instret %0d required 100000 and 0",
                 {illegal, mem_req, MemWrite, IRWrite, PCWrite, RegWrite}, instret);
      end
    end
    do_reset();
    #1;
    n_cmp++;
    if (illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL trap_clear: got illegal %b required 0", illegal);
    end
    op = OP_BR; funct3 = 3'd2;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({illegal, mem_req, PCWrite} !== 3'b100 || instret !== 32'd0) begin
      n_bad++;
      $display("FAIL branch_trap: got %b instret %0d required 100 and 0",
               {illegal, mem_req, PCWrite}, instret);
    end
    do_reset();
    run_instr("lui_u_off", OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if ({b_illegal, b_mem_req, b_IRWrite, b_PCWrite, b_RegWrite, b_MemWrite} !== 6'b100000 ||
        b_instret !== 4'd0) begin
      n_bad++;
      $display("FAIL lui_disabled: got %b instret %0d required 100000 and 0",
               {b_illegal, b_mem_req, b_IRWrite, b_PCWrite, b_RegWrite, b_MemWrite}, b_instret);
    end
  endtask

  task automatic test_instret_wrap();
    logic [2:0] f3;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      f3 = 3'($urandom_range(0, 7));
      run_instr("wrap", (i % 2 == 0) ? OP_R : OP_I, f3, 1'($urandom_range(0, 1)),
                1'b0, 1'b0, 0, 0);
    end
    n_cmp++;
    if (b_instret !== 4'd1) begin
      n_bad++;
      $display("FAIL instret_wrap: got %0d required 1", b_instret);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [2:0] br_f3 [6];
    logic [6:0] o;
    logic [2:0] f3;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    do_reset();
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 8)];
      f3 = (o == OP_BR) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      run_instr("rand", o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_alu_branch();
    test_mem();
    test_jump_u();
    test_trap();
    test_instret_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
